fp_vec_checker: RTL and testbench

FP_VEC_CHECKER -- requirements
Module: fp_vec_checker

---
 rtl/fp_vec_checker_if.sv | 37 +++
 rtl/fp_vec_checker.sv | 194 +++++++++++++++++++
 tb/tb_fp_vec_checker.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_vec_checker_if.sv
// fp_vec_checker_if: bundle between the vector checker, its vector memories
// and the floating-point unit being checked. The checker uses the slave
// modport; the environment (memories, unit under test, control) uses master.
interface fp_vec_checker_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32
);
    logic             start;
    logic             pause;
    logic [CNT_W-1:0] vec_addr;
    logic [WIDTH-1:0] vec_a;
    logic [WIDTH-1:0] vec_b;
    logic [WIDTH-1:0] vec_r;
    logic [WIDTH-1:0] dut_a;
    logic [WIDTH-1:0] dut_b;
    logic             dut_valid;
    logic [WIDTH-1:0] dut_z;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic             first_fail_vld;
    logic [CNT_W-1:0] first_fail_idx;
    logic             all_pass;

    modport master (
        output start, pause, vec_a, vec_b, vec_r, dut_z,
        input  vec_addr, dut_a, dut_b, dut_valid, busy, done,
               pass_cnt, fail_cnt, first_fail_vld, first_fail_idx, all_pass
    );

    modport slave (
        input  start, pause, vec_a, vec_b, vec_r, dut_z,
        output vec_addr, dut_a, dut_b, dut_valid, busy, done,
               pass_cnt, fail_cnt, first_fail_vld, first_fail_idx, all_pass
    );
endinterface

// File: rtl/fp_vec_checker.sv
// fp_vec_checker: walks N_TESTS stored vectors, feeds the operands to an
// external floating-point unit with LAT cycles of latency, and compares each
// result against the stored expected value, counting passes and failures and
// remembering the index of the first failure.
// Build option FP_NAN_EQ_EN: when defined, a NaN result matches any expected
// NaN regardless of sign and payload; otherwise only bitwise equality passes.
module fp_vec_checker #(
    parameter int WIDTH     = 32,
    parameter int EXP_BITS  = 8,
    parameter int FRAC_BITS = 23,
    parameter int N_TESTS   = 10000,
    parameter int LAT       = 0,
    parameter int CNT_W     = 32
) (
    input  logic            clk,
    input  logic            reset,
    fp_vec_checker_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_TESTS - 1);

    // The float format is described twice; refuse to build if they disagree.
    if (WIDTH != 1 + EXP_BITS + FRAC_BITS) begin : g_bad_fmt
        $error("fp_vec_checker: WIDTH must equal 1+EXP_BITS+FRAC_BITS");
    end

    state_t           state;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] vec_addr;
    logic [WIDTH-1:0] dut_a;
    logic [WIDTH-1:0] dut_b;

    // Expected-result pipeline: stage 0 is aligned with dut_a/dut_b, stage
    // LAT is aligned with dut_z.
    logic             vld_p [0:LAT];
    logic [WIDTH-1:0] exp_p [0:LAT];
    logic [CNT_W-1:0] idx_p [0:LAT];

    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic             first_fail_vld;
    logic [CNT_W-1:0] first_fail_idx;

    logic             start_ok;
    logic             issue;
    logic             cmp_vld;
    logic [WIDTH-1:0] cmp_exp;
    logic [CNT_W-1:0] cmp_idx;
    logic             cmp_ok;
    logic             last_cmp;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

`ifdef FP_NAN_EQ_EN
    function automatic logic is_nan(input logic [WIDTH-1:0] x);
        return (&x[WIDTH-2 -: EXP_BITS]) && (|x[FRAC_BITS-1:0]);
    endfunction
`endif

    function automatic logic results_match(input logic [WIDTH-1:0] z,
                                           input logic [WIDTH-1:0] e);
`ifdef FP_NAN_EQ_EN
        return (z == e) || (is_nan(z) && is_nan(e));
`else
        return z == e;
`endif
    endfunction

    // start is honoured only while idle or finished
    assign start_ok = bus.start && ((state == IDLE) || (state == DONE));
    assign issue    = (state == RUN) && !bus.pause;

    assign cmp_vld  = vld_p[LAT];
    assign cmp_exp  = exp_p[LAT];
    assign cmp_idx  = idx_p[LAT];
    assign cmp_ok   = results_match(bus.dut_z, cmp_exp);
    // Indices leave the pipeline in order, so the last index marks the end.
    assign last_cmp = cmp_vld && (cmp_idx == LAST_IDX);

    // Run-control FSM: walks the vector index and reports busy/done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            vec_addr <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        vec_addr <= '0;
                    end
                end
                RUN: begin
                    if (!bus.pause) begin
                        vec_addr <= vec_addr + 1'b1;
                        if (vec_addr == LAST_IDX) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (last_cmp) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand issue and expected-result delay line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dut_a <= '0;
            dut_b <= '0;
            for (int i = 0; i <= LAT; i++) begin
                vld_p[i] <= 1'b0;
                exp_p[i] <= '0;
                idx_p[i] <= '0;
            end
        end else begin
            // ---- stage 0: operands to the unit, expected value alongside ----
            vld_p[0] <= issue;
            if (issue) begin
                dut_a    <= bus.vec_a;
                dut_b    <= bus.vec_b;
                exp_p[0] <= bus.vec_r;
                idx_p[0] <= vec_addr;
            end
            // ---- stages 1..LAT: track the unit's internal latency ----
            for (int i = 1; i <= LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
                exp_p[i] <= exp_p[i-1];
                idx_p[i] <= idx_p[i-1];
            end
        end
    end

    // Result comparison: saturating pass/fail counters and first-failure capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_vld <= 1'b0;
            first_fail_idx <= '0;
        end else if (start_ok) begin
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_vld <= 1'b0;
            first_fail_idx <= '0;
        end else if (cmp_vld) begin
            if (cmp_ok) begin
                pass_cnt <= sat_inc(pass_cnt);
            end else begin
                fail_cnt <= sat_inc(fail_cnt);
                if (!first_fail_vld) begin
                    first_fail_vld <= 1'b1;
                    first_fail_idx <= cmp_idx;
                end
            end
        end
    end

    // Every vector is compared exactly once by the time the run finishes.
    always_ff @(posedge clk) begin
        if (done) begin
            assert (({1'b0, pass_cnt} + {1'b0, fail_cnt}) == (CNT_W+1)'(N_TESTS));
        end
    end

    assign bus.vec_addr       = vec_addr;
    assign bus.dut_a          = dut_a;
    assign bus.dut_b          = dut_b;
    assign bus.dut_valid      = vld_p[0];
    assign bus.busy           = busy;
    assign bus.done           = done;
    assign bus.pass_cnt       = pass_cnt;
    assign bus.fail_cnt       = fail_cnt;
    assign bus.first_fail_vld = first_fail_vld;
    assign bus.first_fail_idx = first_fail_idx;
    assign bus.all_pass       = done && (fail_cnt == '0);

endmodule

// File: tb/tb_fp_vec_checker.sv
// tb_fp_vec_checker: three checker instances (N=4/LAT=0, N=8/LAT=3,
// N=8/LAT=2) each driving a small lookup-table model of an ideal adder.
module tb_fp_vec_checker;

    logic clk;
    logic reset;

    int checks;
    int errors;

    typedef struct {
        int pass;
        int fail;
        bit ffv;
        int ffi;
        int cyc;
        int gap;
    } res_t;

    res_t res_q[$];
    int   idx_q[$];

    logic [2:0]  start_v;
    logic [2:0]  pause_v;
    logic [31:0] va [3][8];
    logic [31:0] vb [3][8];
    logic [31:0] vr [3][8];

    logic        ovr_en;
    logic [31:0] ovr_z;

    logic [2:0]  done_v, busy_v, valid_v, ffv_v, allp_v;
    logic [31:0] pass_v [3];
    logic [31:0] fail_v [3];
    logic [31:0] ffi_v  [3];
    logic [31:0] addr_v [3];
    logic [31:0] da_v   [3];
    logic [31:0] db_v   [3];

    logic [31:0] z3 [3];
    logic [31:0] z2 [2];

    fp_vec_checker_if #(.WIDTH(32), .CNT_W(32)) if0 ();
    fp_vec_checker_if #(.WIDTH(32), .CNT_W(32)) if1 ();
    fp_vec_checker_if #(.WIDTH(32), .CNT_W(32)) if2 ();

    fp_vec_checker #(.N_TESTS(4), .LAT(0)) u0 (.clk(clk), .reset(reset), .bus(if0.slave));
    fp_vec_checker #(.N_TESTS(8), .LAT(3)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));
    fp_vec_checker #(.N_TESTS(8), .LAT(2)) u2 (.clk(clk), .reset(reset), .bus(if2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lookup model of an ideal single-precision adder for the bench's vectors.
    function automatic logic [31:0] ideal(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F800000, 32'h40000000}, {32'h40000000, 32'h3F800000}: return 32'h40400000;
            {32'h40000000, 32'h40000000}, {32'h40400000, 32'h3F800000}: return 32'h40800000;
            {32'h3F800000, 32'h3F800000}: return 32'h40000000;
            {32'h3F000000, 32'h3F000000}: return 32'h3F800000;
            {32'h3F800000, 32'h3F000000}: return 32'h3FC00000;
            default: return 32'h7FBADBAD;
        endcase
    endfunction

    function automatic bit model_match(input logic [31:0] z, input logic [31:0] e);
`ifdef FP_NAN_EQ_EN
        bit zn, en;
        zn = (z[30:23] == 8'hFF) && (z[22:0] != 23'd0);
        en = (e[30:23] == 8'hFF) && (e[22:0] != 23'd0);
        if (zn && en) return 1'b1;
`endif
        return z === e;
    endfunction

    function automatic logic [31:0] model_z(input int sel, input int i);
        if (sel == 0 && ovr_en) return ovr_z;
        return ideal(va[sel][i], vb[sel][i]);
    endfunction

    assign if0.start = start_v[0];
    assign if1.start = start_v[1];
    assign if2.start = start_v[2];
    assign if0.pause = pause_v[0];
    assign if1.pause = pause_v[1];
    assign if2.pause = pause_v[2];

    assign if0.vec_a = va[0][if0.vec_addr[2:0]];
    assign if0.vec_b = vb[0][if0.vec_addr[2:0]];
    assign if0.vec_r = vr[0][if0.vec_addr[2:0]];
    assign if1.vec_a = va[1][if1.vec_addr[2:0]];
    assign if1.vec_b = vb[1][if1.vec_addr[2:0]];
    assign if1.vec_r = vr[1][if1.vec_addr[2:0]];
    assign if2.vec_a = va[2][if2.vec_addr[2:0]];
    assign if2.vec_b = vb[2][if2.vec_addr[2:0]];
    assign if2.vec_r = vr[2][if2.vec_addr[2:0]];

    // Unit models: combinational, 3-cycle and 2-cycle pipelines.
    assign if0.dut_z = ovr_en ? ovr_z : ideal(if0.dut_a, if0.dut_b);
    always @(posedge clk) begin
        z3[0] <= ideal(if1.dut_a, if1.dut_b);
        z3[1] <= z3[0];
        z3[2] <= z3[1];
        z2[0] <= ideal(if2.dut_a, if2.dut_b);
        z2[1] <= z2[0];
    end
    assign if1.dut_z = z3[2];
    assign if2.dut_z = z2[1];

    assign done_v  = {if2.done, if1.done, if0.done};
    assign busy_v  = {if2.busy, if1.busy, if0.busy};
    assign valid_v = {if2.dut_valid, if1.dut_valid, if0.dut_valid};
    assign ffv_v   = {if2.first_fail_vld, if1.first_fail_vld, if0.first_fail_vld};
    assign allp_v  = {if2.all_pass, if1.all_pass, if0.all_pass};
    assign pass_v[0] = if0.pass_cnt;
    assign pass_v[1] = if1.pass_cnt;
    assign pass_v[2] = if2.pass_cnt;
    assign fail_v[0] = if0.fail_cnt;
    assign fail_v[1] = if1.fail_cnt;
    assign fail_v[2] = if2.fail_cnt;
    assign ffi_v[0]  = if0.first_fail_idx;
    assign ffi_v[1]  = if1.first_fail_idx;
    assign ffi_v[2]  = if2.first_fail_idx;
    assign addr_v[0] = if0.vec_addr;
    assign addr_v[1] = if1.vec_addr;
    assign addr_v[2] = if2.vec_addr;
    assign da_v[0]   = if0.dut_a;
    assign da_v[1]   = if1.dut_a;
    assign da_v[2]   = if2.dut_a;
    assign db_v[0]   = if0.dut_b;
    assign db_v[1]   = if1.dut_b;
    assign db_v[2]   = if2.dut_b;

    task automatic init_vectors();
        logic [31:0] ta [8];
        logic [31:0] tb [8];
        logic [31:0] tr [8];
        ta = '{32'h3F800000, 32'h40000000, 32'h3F800000, 32'h3F000000,
               32'h40400000, 32'h40000000, 32'h3F800000, 32'h3F800000};
        tb = '{32'h40000000, 32'h40000000, 32'h3F800000, 32'h3F000000,
               32'h3F800000, 32'h3F800000, 32'h40000000, 32'h3F000000};
        tr = '{32'h40400000, 32'h40800000, 32'h40000000, 32'h3F800000,
               32'h40800000, 32'h40400000, 32'h40400000, 32'h3FC00000};
        for (int i = 0; i < 8; i++) begin
            va[0][i] = 32'h3F800000;
            vb[0][i] = 32'h40000000;
            vr[0][i] = 32'h40400000;
            for (int s = 1; s < 3; s++) begin
                va[s][i] = ta[i];
                vb[s][i] = tb[i];
                vr[s][i] = tr[i];
            end
        end
    endtask

    task automatic check_all_zero(input int sel, input string tag);
        checks++;
        if (busy_v[sel] !== 1'b0 || done_v[sel] !== 1'b0 || valid_v[sel] !== 1'b0 ||
            ffv_v[sel] !== 1'b0 || allp_v[sel] !== 1'b0) begin
            errors++;
            $display("FAIL %s_flags sel=%0d: busy=%b done=%b valid=%b ffv=%b all_pass=%b, required all 0",
                     tag, sel, busy_v[sel], done_v[sel], valid_v[sel], ffv_v[sel], allp_v[sel]);
        end
        checks++;
        if (pass_v[sel] !== 32'd0 || fail_v[sel] !== 32'd0 || ffi_v[sel] !== 32'd0 ||
            addr_v[sel] !== 32'd0 || da_v[sel] !== 32'd0 || db_v[sel] !== 32'd0) begin
            errors++;
            $display("FAIL %s_words sel=%0d: pass=%0d fail=%0d ffi=%0d addr=%0d a=%h b=%h, required all 0",
                     tag, sel, pass_v[sel], fail_v[sel], ffi_v[sel], addr_v[sel], da_v[sel], db_v[sel]);
        end
    endtask

    // One complete run on instance sel with scoreboarded issue order and results.
    task automatic run_vec(input int sel, input int n, input int lat,
                           input int pause_len, input int restart_at);
        res_t r, e;
        int cyc, gap, popped, pcnt, idx;
        bit ptrig, rtrig, seen;
        logic [31:0] z;
        r.pass = 0; r.fail = 0; r.ffv = 0; r.ffi = 0;
        for (int i = 0; i < n; i++) begin
            idx_q.push_back(i);
            z = model_z(sel, i);
            if (model_match(z, vr[sel][i])) r.pass++;
            else begin
                if (!r.ffv) begin r.ffv = 1; r.ffi = i; end
                r.fail++;
            end
        end
        r.cyc = n + lat + 1 + pause_len;
        r.gap = pause_len;
        res_q.push_back(r);

        @(negedge clk); start_v[sel] = 1'b1;
        @(negedge clk); start_v[sel] = 1'b0;
        checks++;
        if (busy_v[sel] !== 1'b1 || done_v[sel] !== 1'b0 || pass_v[sel] !== 32'd0 ||
            fail_v[sel] !== 32'd0 || ffv_v[sel] !== 1'b0) begin
            errors++;
            $display("FAIL start_clear sel=%0d: busy=%b done=%b pass=%0d fail=%0d ffv=%b, required busy=1 rest 0",
                     sel, busy_v[sel], done_v[sel], pass_v[sel], fail_v[sel], ffv_v[sel]);
        end

        cyc = 0; gap = 0; popped = 0; pcnt = 0; ptrig = 0; rtrig = 0; seen = 0;
        while (done_v[sel] !== 1'b1 && cyc < 200) begin
            if (valid_v[sel] === 1'b1) begin
                seen = 1;
                checks++;
                if (idx_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_issue sel=%0d: a=%h b=%h, required no further issue", sel, da_v[sel], db_v[sel]);
                end else begin
                    idx = idx_q.pop_front();
                    popped++;
                    if (da_v[sel] !== va[sel][idx] || db_v[sel] !== vb[sel][idx]) begin
                        errors++;
                        $display("FAIL issue_operands sel=%0d idx=%0d: a=%h b=%h, required a=%h b=%h",
                                 sel, idx, da_v[sel], db_v[sel], va[sel][idx], vb[sel][idx]);
                    end
                end
            end else if (seen && popped < n) begin
                gap++;
            end
            if (restart_at >= 0 && !rtrig && addr_v[sel] == 32'(restart_at)) begin
                rtrig = 1;
                start_v[sel] = 1'b1;
            end else begin
                start_v[sel] = 1'b0;
            end
            if (pause_len > 0 && !ptrig && addr_v[sel] == 32'd2) begin
                ptrig = 1;
                pcnt = pause_len;
            end
            if (pcnt > 0) begin
                pause_v[sel] = 1'b1;
                pcnt--;
            end else begin
                pause_v[sel] = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start_v[sel] = 1'b0;
        pause_v[sel] = 1'b0;

        e = res_q.pop_front();
        checks++;
        if (done_v[sel] !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout sel=%0d: done=%b after %0d cycles, required 1", sel, done_v[sel], cyc);
        end
        checks++;
        if (cyc != e.cyc) begin
            errors++;
            $display("FAIL run_length sel=%0d: %0d cycles, required %0d", sel, cyc, e.cyc);
        end
        checks++;
        if (popped != n || idx_q.size() != 0) begin
            errors++;
            $display("FAIL issue_count sel=%0d: %0d issued, required %0d", sel, popped, n);
            idx_q.delete();
        end
        checks++;
        if (gap != e.gap) begin
            errors++;
            $display("FAIL valid_gap sel=%0d: %0d idle cycles, required %0d", sel, gap, e.gap);
        end
        checks++;
        if (pass_v[sel] !== 32'(e.pass) || fail_v[sel] !== 32'(e.fail)) begin
            errors++;
            $display("FAIL counts sel=%0d: pass=%0d fail=%0d, required pass=%0d fail=%0d",
                     sel, pass_v[sel], fail_v[sel], e.pass, e.fail);
        end
        checks++;
        if (ffv_v[sel] !== e.ffv || ffi_v[sel] !== 32'(e.ffi)) begin
            errors++;
            $display("FAIL first_fail sel=%0d: vld=%b idx=%0d, required vld=%b idx=%0d",
                     sel, ffv_v[sel], ffi_v[sel], e.ffv, e.ffi);
        end
        checks++;
        if (allp_v[sel] !== (e.fail == 0)) begin
            errors++;
            $display("FAIL all_pass sel=%0d: %b, required %b", sel, allp_v[sel], (e.fail == 0));
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done_v[sel] !== 1'b1 || busy_v[sel] !== 1'b0 ||
            pass_v[sel] !== 32'(e.pass) || fail_v[sel] !== 32'(e.fail)) begin
            errors++;
            $display("FAIL done_hold sel=%0d: done=%b busy=%b pass=%0d fail=%0d, required done=1 busy=0 pass=%0d fail=%0d",
                     sel, done_v[sel], busy_v[sel], pass_v[sel], fail_v[sel], e.pass, e.fail);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) check_all_zero(s, "reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) check_all_zero(s, "post_reset_idle");
    endtask

    task automatic test_basic_lat0();
        run_vec(0, 4, 0, 0, -1);
    endtask

    task automatic test_nan();
        for (int i = 0; i < 4; i++) vr[0][i] = 32'h7FC00000;
        ovr_en = 1'b1;
        ovr_z  = 32'hFFC00001;
        run_vec(0, 4, 0, 0, -1);
        ovr_en = 1'b0;
        for (int i = 0; i < 4; i++) vr[0][i] = 32'h40400000;
    endtask

    task automatic test_restart();
        run_vec(0, 4, 0, 0, -1);
    endtask

    task automatic test_start_in_run();
        run_vec(0, 4, 0, 0, 2);
    endtask

    task automatic test_fail_lat3();
        vr[1][5] = 32'h00000000;
        run_vec(1, 8, 3, 0, -1);
    endtask

    task automatic test_pause_lat2();
        run_vec(2, 8, 2, 3, -1);
    endtask

    task automatic test_reset_midrun();
        int w;
        vr[1][5] = 32'h40400000;
        @(negedge clk); start_v[1] = 1'b1;
        @(negedge clk); start_v[1] = 1'b0;
        w = 0;
        while (addr_v[1] !== 32'd3 && w < 50) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (addr_v[1] !== 32'd3 || busy_v[1] !== 1'b1 || valid_v[1] !== 1'b1) begin
            errors++;
            $display("FAIL midrun_reach: addr=%0d busy=%b valid=%b, required addr=3 busy=1 valid=1",
                     addr_v[1], busy_v[1], valid_v[1]);
        end
        #2 reset = 1'b1;
        #1;
        check_all_zero(1, "async_reset");
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero(1, "reset_needs_start");
        run_vec(1, 8, 3, 0, -1);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        start_v = '0;
        pause_v = '0;
        ovr_en  = 1'b0;
        ovr_z   = '0;
        reset   = 1'b1;
        init_vectors();

        test_reset();
        test_basic_lat0();
        test_nan();
        test_restart();
        test_start_in_run();
        test_fail_lat3();
        test_pause_lat2();
        test_reset_midrun();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
